// File: rtl/sfu_acc_pkg.sv
// Shared accelerator definitions: default datapath widths and the
// partial-sum accumulator state encoding.
package sfu_acc_pkg;

    localparam int default_psum_bw = 16;
    localparam int default_pass_bw = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/sfu_acc_sat_relu.sv
// Combinational output stage: saturate a wide signed value into the narrow
// signed range, then optionally clamp negative values to zero.
module sat_relu #(
    parameter int in_bw  = 20,
    parameter int out_bw = 16
) (
    input  logic signed [in_bw-1:0]  din,
    input  logic                     relu_en,
    output logic signed [out_bw-1:0] dout
);

    logic [in_bw-out_bw:0]    top_bits;
    logic signed [out_bw-1:0] sat;

    assign top_bits = din[in_bw-1:out_bw-1];

    // The value fits only when every bit above the output sign bit copies it.
    always_comb begin
        sat = din[out_bw-1:0];
        if (!(top_bits == '0 || top_bits == '1)) begin
            if (din[in_bw-1]) begin
                sat = {1'b1, {(out_bw-1){1'b0}}};
            end else begin
                sat = {1'b0, {(out_bw-1){1'b1}}};
            end
        end
        dout = (relu_en && sat[out_bw-1]) ? '0 : sat;
    end

endmodule

// File: rtl/sfu_acc.sv
// Partial-sum accumulator: sums num_pass psums from the MAC into a wide
// accumulator, then hands off one saturated (optionally ReLU'd) result.
module sfu_acc
    import sfu_acc_pkg::*;
#(
    parameter int psum_bw = default_psum_bw,
    parameter int pass_bw = default_pass_bw
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic signed [psum_bw-1:0] in_psum,
    output logic                      in_ready,
    input  logic [pass_bw-1:0]        num_pass,
    input  logic                      relu_en,
    output logic                      out_valid,
    output logic signed [psum_bw-1:0] out_data,
    input  logic                      out_ready,
    output logic [7:0]                out_count
);

    localparam int acc_bw = psum_bw + pass_bw;

    state_t                   state;
    logic signed [acc_bw-1:0] acc;
    logic signed [acc_bw-1:0] acc_base;
    logic signed [acc_bw-1:0] acc_next;
    logic [pass_bw-1:0]       cnt;
    logic [pass_bw-1:0]       cnt_base;
    logic [pass_bw-1:0]       pass_q;
    logic [pass_bw-1:0]       cur_pass;
    logic                     relu_q;
    logic                     cur_relu;
    logic                     first;
    logic                     done;
    logic                     accept;
    logic                     handoff;
    logic signed [psum_bw-1:0] result;

    assign in_ready = (state == HOLD) ? out_ready : 1'b1;
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;

    // Any accept outside ACC opens a new group and samples the live config.
    assign first    = (state != ACC);
    assign cur_pass = first ? ((num_pass == '0) ? pass_bw'(1) : num_pass) : pass_q;
    assign cur_relu = first ? relu_en : relu_q;
    assign acc_base = first ? '0 : acc;
    assign cnt_base = first ? '0 : cnt;
    assign acc_next = acc_base + $signed({{pass_bw{in_psum[psum_bw-1]}}, in_psum});
    assign done     = (({1'b0, cnt_base} + (pass_bw+1)'(1)) == {1'b0, cur_pass});

    sat_relu #(
        .in_bw  (acc_bw),
        .out_bw (psum_bw)
    ) u_sat_relu (
        .din     (acc_next),
        .relu_en (cur_relu),
        .dout    (result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            pass_q    <= '0;
            relu_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            if (handoff) begin
                out_count <= out_count + 8'(1);
            end
            if (accept) begin
                pass_q <= cur_pass;
                relu_q <= cur_relu;
                if (done) begin
                    acc       <= '0;
                    cnt       <= '0;
                    out_data  <= result;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end else begin
                    acc       <= acc_next;
                    cnt       <= cnt_base + pass_bw'(1);
                    out_valid <= 1'b0;
                    state     <= ACC;
                end
            end else if (handoff) begin
                out_valid <= 1'b0;
                state     <= IDLE;
            end
        end
    end

endmodule
